// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS BCD timer: state encodings, mode codes,
// BCD digit limits and the load-value clamp helper.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_UP_LIMIT = 2'b00;
  localparam logic [1:0] MODE_DN_LIMIT = 2'b01;
  localparam logic [1:0] MODE_UP_LOAD  = 2'b10;
  localparam logic [1:0] MODE_DN_LOAD  = 2'b11;

  localparam logic [3:0] DIGIT_MAX_DEC = 4'd9;
  localparam logic [3:0] DIGIT_MAX_SEX = 4'd5;

  // Force an arbitrary 16-bit preset into a legal MM:SS BCD value.
  function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (r[15:12] > DIGIT_MAX_DEC) r[15:12] = DIGIT_MAX_DEC;
    if (r[11:8]  > DIGIT_MAX_DEC) r[11:8]  = DIGIT_MAX_DEC;
    if (r[7:4]   > DIGIT_MAX_SEX) r[7:4]   = DIGIT_MAX_SEX;
    if (r[3:0]   > DIGIT_MAX_DEC) r[3:0]   = DIGIT_MAX_DEC;
    return r;
  endfunction

endpackage

// File: rtl/timer_if.sv
// Control/status bundle between the tick divider, the timer core and the display path.
interface timer_if;
  logic        tick;
  logic [1:0]  mode;
  logic [15:0] load_val;
  logic        start;
  logic        clear;
  logic        lap;
  logic [15:0] digits;
  logic        running;
  logic        done;

  modport master (
    output tick, mode, load_val, start, clear, lap,
    input  digits, running, done
  );

  modport slave (
    input  tick, mode, load_val, start, clear, lap,
    output digits, running, done
  );
endinterface

// File: rtl/bcd_digit.sv
// One mod-N BCD digit of the count chain: computes the stepped value and a
// wrap flag that enables the next more-significant digit.
module bcd_digit
  import timer_pkg::*;
#(
  parameter int N = int'(DIGIT_MAX_DEC) + 1
) (
  input  logic [3:0] digit_i,
  input  logic       en_i,
  input  logic       dir_i,
  output logic [3:0] digit_o,
  output logic       wrap_o
);

  localparam logic [3:0] MAX = 4'(N - 1);

  always_comb begin
    digit_o = digit_i;
    wrap_o  = 1'b0;
    if (en_i) begin
      if (!dir_i) begin
        if (digit_i == MAX) begin
          digit_o = 4'd0;
          wrap_o  = 1'b1;
        end else begin
          digit_o = digit_i + 4'd1;
        end
      end else begin
        if (digit_i == 4'd0) begin
          digit_o = MAX;
          wrap_o  = 1'b1;
        end else begin
          digit_o = digit_i - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/timer_core.sv
// Four-function MM:SS BCD timer core: FSM, tick prescaler, target compare and display mux.
// Optional lap-hold display freeze is built when TIMER_LAP_EN is defined.
module timer_core
  import timer_pkg::*;
#(
  parameter int          TICKS_PER_STEP = 1,
  parameter logic [15:0] LIMIT          = 16'h9959
) (
  input  logic   clk,
  input  logic   rst_n,
  timer_if.slave bus
);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] target_q, target_d;
  logic [7:0]  presc_q, presc_d;
  logic        dir_q, dir_d;

  logic [15:0] load_l;
  logic [15:0] init_v;
  logic [15:0] tgt_v;
  logic        dir_v;
  logic [7:0]  presc_inc;
  logic [15:0] count_step;
  logic [2:0]  carry;
  logic        carry_unused;

  // The chain always computes count +/- 1; the FSM decides whether to take it.
  bcd_digit #(.N(10)) u_s1 (
    .digit_i(count_q[3:0]),   .en_i(1'b1),     .dir_i(dir_q),
    .digit_o(count_step[3:0]), .wrap_o(carry[0])
  );
  bcd_digit #(.N(6)) u_s10 (
    .digit_i(count_q[7:4]),   .en_i(carry[0]), .dir_i(dir_q),
    .digit_o(count_step[7:4]), .wrap_o(carry[1])
  );
  bcd_digit #(.N(10)) u_m1 (
    .digit_i(count_q[11:8]),  .en_i(carry[0] & carry[1]), .dir_i(dir_q),
    .digit_o(count_step[11:8]), .wrap_o(carry[2])
  );
  bcd_digit #(.N(10)) u_m10 (
    .digit_i(count_q[15:12]), .en_i(carry[0] & carry[1] & carry[2]), .dir_i(dir_q),
    .digit_o(count_step[15:12]), .wrap_o(carry_unused)
  );

  always_comb begin
    load_l = clamp_bcd(bus.load_val);
    init_v = 16'h0000;
    tgt_v  = LIMIT;
    dir_v  = 1'b0;
    case (bus.mode)
      MODE_UP_LIMIT: begin init_v = 16'h0000; tgt_v = LIMIT;    dir_v = 1'b0; end
      MODE_DN_LIMIT: begin init_v = LIMIT;    tgt_v = 16'h0000; dir_v = 1'b1; end
      MODE_UP_LOAD:  begin init_v = 16'h0000; tgt_v = load_l;   dir_v = 1'b0; end
      MODE_DN_LOAD:  begin init_v = load_l;   tgt_v = 16'h0000; dir_v = 1'b1; end
      default: ;
    endcase
  end

  // clear beats start beats tick; start always swallows a same-cycle tick.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    target_d  = target_q;
    presc_d   = presc_q;
    dir_d     = dir_q;
    presc_inc = presc_q + 8'd1;
    if (bus.clear) begin
      state_d = ST_IDLE;
      count_d = 16'h0000;
      presc_d = 8'd0;
    end else if (bus.start) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          count_d  = init_v;
          target_d = tgt_v;
          dir_d    = dir_v;
          presc_d  = 8'd0;
          state_d  = (init_v == tgt_v) ? ST_DONE : ST_RUN;
        end
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end else if (bus.tick && state_q == ST_RUN) begin
      if (presc_inc == 8'(TICKS_PER_STEP)) begin
        presc_d = 8'd0;
        count_d = count_step;
        if (count_step == target_q) state_d = ST_DONE;
      end else begin
        presc_d = presc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= 16'h0000;
      target_q <= 16'h0000;
      presc_q  <= 8'd0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      presc_q  <= presc_d;
      dir_q    <= dir_d;
    end
  end

  assign bus.running = (state_q == ST_RUN);
  assign bus.done    = (state_q == ST_DONE);

`ifdef TIMER_LAP_EN
  logic        lap_hold_q, lap_hold_d;
  logic [15:0] lap_val_q, lap_val_d;

  // The snapshot takes the post-edge count so the display does not jump on toggle-on.
  always_comb begin
    lap_hold_d = lap_hold_q;
    lap_val_d  = lap_val_q;
    if (state_d == ST_IDLE || state_d == ST_DONE) begin
      lap_hold_d = 1'b0;
    end else if (bus.lap && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
      lap_hold_d = ~lap_hold_q;
      if (!lap_hold_q) lap_val_d = count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_hold_q <= 1'b0;
      lap_val_q  <= 16'h0000;
    end else begin
      lap_hold_q <= lap_hold_d;
      lap_val_q  <= lap_val_d;
    end
  end

  assign bus.digits = lap_hold_q ? lap_val_q : count_q;
`else
  logic unused_lap;
  assign unused_lap = bus.lap;
  assign bus.digits = count_q;
`endif

endmodule

// File: tb/tb_timer_core.sv
// Randomized bench for timer_core: two instances (1 and 4 ticks per step) share
// stimulus and are compared every cycle against a seconds-based reference model.
module tb_timer_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        i_tick, i_start, i_clear, i_lap;
  logic [1:0]  i_mode;
  logic [15:0] i_load;

  timer_if bus1 ();
  timer_if bus4 ();

  assign bus1.tick = i_tick;   assign bus4.tick = i_tick;
  assign bus1.start = i_start; assign bus4.start = i_start;
  assign bus1.clear = i_clear; assign bus4.clear = i_clear;
  assign bus1.lap = i_lap;     assign bus4.lap = i_lap;
  assign bus1.mode = i_mode;   assign bus4.mode = i_mode;
  assign bus1.load_val = i_load; assign bus4.load_val = i_load;

  timer_core #(.TICKS_PER_STEP(1), .LIMIT(16'h9959)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  timer_core #(.TICKS_PER_STEP(4), .LIMIT(16'h9959)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  localparam int LIMIT_SEC = 99 * 60 + 59;

  // Reference model state, in whole seconds. st: 0 idle, 1 run, 2 pause, 3 done.
  int m_st[2], m_cnt[2], m_tgt[2], m_presc[2], m_lap[2], m_lapv[2];
  int m_tps[2] = '{1, 4};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int clamp_sec(input logic [15:0] b);
    int m10, m1, s10, s1;
    m10 = int'(b[15:12]); m1 = int'(b[11:8]); s10 = int'(b[7:4]); s1 = int'(b[3:0]);
    if (m10 > 9) m10 = 9;
    if (m1 > 9) m1 = 9;
    if (s10 > 5) s10 = 5;
    if (s1 > 9) s1 = 9;
    return (m10 * 10 + m1) * 60 + s10 * 10 + s1;
  endfunction

  function automatic logic [15:0] sec2bcd(input int s);
    int m, ss;
    m = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_cnt[k] = 0; m_tgt[k] = 0;
      m_presc[k] = 0; m_lap[k] = 0; m_lapv[k] = 0;
    end
  endtask

  task automatic model_edge(input int k);
    int prev, init, tgt;
    prev = m_st[k];
    if (i_clear) begin
      m_st[k] = 0; m_cnt[k] = 0; m_presc[k] = 0;
    end else if (i_start) begin
      if (prev == 0 || prev == 3) begin
        case (i_mode)
          2'b00:   begin init = 0; tgt = LIMIT_SEC; end
          2'b01:   begin init = LIMIT_SEC; tgt = 0; end
          2'b10:   begin init = 0; tgt = clamp_sec(i_load); end
          default: begin init = clamp_sec(i_load); tgt = 0; end
        endcase
        m_cnt[k] = init; m_tgt[k] = tgt; m_presc[k] = 0;
        m_st[k] = (init == tgt) ? 3 : 1;
      end else begin
        m_st[k] = (prev == 1) ? 2 : 1;
      end
    end else if (i_tick && prev == 1) begin
      m_presc[k]++;
      if (m_presc[k] == m_tps[k]) begin
        m_presc[k] = 0;
        m_cnt[k] += (m_cnt[k] < m_tgt[k]) ? 1 : -1;
        if (m_cnt[k] == m_tgt[k]) m_st[k] = 3;
      end
    end
`ifdef TIMER_LAP_EN
    if (m_st[k] == 0 || m_st[k] == 3) begin
      m_lap[k] = 0;
    end else if (i_lap && (prev == 1 || prev == 2)) begin
      if (m_lap[k] == 0) m_lapv[k] = m_cnt[k];
      m_lap[k] = (m_lap[k] == 0) ? 1 : 0;
    end
`endif
  endtask

  function automatic logic [15:0] model_digits(input int k);
    return sec2bcd((m_lap[k] != 0) ? m_lapv[k] : m_cnt[k]);
  endfunction

  task automatic check_outputs();
    check_eq("digits_tps1",  32'(bus1.digits),  32'(model_digits(0)));
    check_eq("running_tps1", 32'(bus1.running), 32'(m_st[0] == 1));
    check_eq("done_tps1",    32'(bus1.done),    32'(m_st[0] == 3));
    check_eq("digits_tps4",  32'(bus4.digits),  32'(model_digits(1)));
    check_eq("running_tps4", 32'(bus4.running), 32'(m_st[1] == 1));
    check_eq("done_tps4",    32'(bus4.done),    32'(m_st[1] == 3));
  endtask

  // One clock: drive after the falling edge, update model at the rising edge, sample 1ns later.
  task automatic drive(input logic t, input logic s, input logic c, input logic l);
    i_tick = t; i_start = s; i_clear = c; i_lap = l;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_outputs();
    @(negedge clk);
    i_tick = 1'b0; i_start = 1'b0; i_clear = 1'b0; i_lap = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    i_tick = 1'b0; i_start = 1'b0; i_clear = 1'b0; i_lap = 1'b0;
    i_mode = 2'b00; i_load = 16'h0000;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_digits", 32'(bus1.digits), 32'h0);
    check_eq("reset_flags", {30'd0, bus1.running, bus1.done}, 32'h0);
    check_outputs();
    rst_n = 1'b1;

    // Free-running up: 60 ticks reach one minute.
    i_mode = 2'b00;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(60);
    check_eq("up60_digits", 32'(bus1.digits), 32'h0100);
    check_eq("up60_running", 32'(bus1.running), 32'h1);

    // Count down from a loaded 3 s; finishing tick raises done; extra tick is ignored.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    i_mode = 2'b11; i_load = 16'h0003;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1); check_eq("dn_0002", 32'(bus1.digits), 32'h0002);
    ticks(1); check_eq("dn_0001", 32'(bus1.digits), 32'h0001);
    ticks(1); check_eq("dn_0000", 32'(bus1.digits), 32'h0000);
    check_eq("dn_done", 32'(bus1.done), 32'h1);
    ticks(1); check_eq("dn_hold", 32'(bus1.digits), 32'h0000);

    // init equals target: straight to done.
    i_mode = 2'b10; i_load = 16'h0000;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("zero_done", 32'(bus1.done), 32'h1);
    check_eq("zero_digits", 32'(bus1.digits), 32'h0000);

    // Clamping: 7A8F loads as 7959; up-to 001F stops at 0019.
    i_mode = 2'b11; i_load = 16'h7A8F;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("clamp_7959", 32'(bus1.digits), 32'h7959);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    i_mode = 2'b10; i_load = 16'h001F;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(19);
    check_eq("clamp_up_done", {15'd0, bus1.done, bus1.digits}, {15'd0, 1'b1, 16'h0019});
    ticks(2);
    check_eq("clamp_up_hold", 32'(bus1.digits), 32'h0019);

    // Pause/resume, and ticks coinciding with start are dropped.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    i_mode = 2'b00;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    check_eq("pause_frozen", 32'(bus1.digits), 32'h0010);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    check_eq("resume_0011", 32'(bus1.digits), 32'h0011);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("start_tick_drop", 32'(bus1.digits), 32'h0011);

    // clear+start+tick together at 01:23.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(83);
    check_eq("at_0123", 32'(bus1.digits), 32'h0123);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("clear_wins", {14'd0, bus1.running, bus1.done, bus1.digits}, 32'h0);

    // Asynchronous reset mid-run.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(7);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_tps1", {14'd0, bus1.running, bus1.done, bus1.digits}, 32'h0);
    check_eq("async_rst_tps4", {14'd0, bus4.running, bus4.done, bus4.digits}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Four ticks per step.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(8);
    check_eq("tps4_0002", 32'(bus4.digits), 32'h0002);
`ifdef TIMER_LAP_EN
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(8);
    check_eq("lap_frozen", 32'(bus4.digits), 32'h0002);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("lap_release", 32'(bus4.digits), 32'h0004);
`endif

    // Random traffic against the model.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic t, s, c, l;
      t = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 149) == 0);
      l = ($urandom_range(0, 19) == 0);
      if (s) begin
        i_mode = 2'($urandom);
        i_load = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                             : {12'h000, 4'($urandom_range(0, 15))};
      end
      drive(t, s, c, l);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
